// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: time-multiplexed hex seven-segment driver with shadow regs.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module sevenseg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   Anode_Activate,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [CW-1:0]           cnt;
    logic [3:0]              cur;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   an_on;
    logic                    dp_on;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    dp_nxt;

    // Glyphs are stored in common-anode form (0 = segment lit).
    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'b000_0001;
            4'h1: g = 7'b100_1111;
            4'h2: g = 7'b001_0010;
            4'h3: g = 7'b000_0110;
            4'h4: g = 7'b100_1100;
            4'h5: g = 7'b010_0100;
            4'h6: g = 7'b010_0000;
            4'h7: g = 7'b000_1111;
            4'h8: g = 7'b000_0000;
            4'h9: g = 7'b000_1100;
            4'hA: g = 7'b000_1000;
            4'hB: g = 7'b110_0000;
            4'hC: g = 7'b011_0001;
            4'hD: g = 7'b100_0010;
            4'hE: g = 7'b011_0000;
            default: g = 7'b011_1000;
        endcase
        return g;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Index of the most-significant nonzero digit; 0 when the word is zero.
    function automatic logic [IW-1:0] top_nz(input logic [4*NUM_DIGITS-1:0] d);
        logic [IW-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (d[4*i +: 4] != 4'd0) m = IW'(i);
        return m;
    endfunction
`endif

    // Decode the current digit into lit-high patterns, then apply board polarity.
    always_comb begin
        cur    = shadow_data[4*int'(digit_idx) +: 4];
        seg_on = ~glyph(cur);
        an_on  = NUM_DIGITS'(1) << digit_idx;
        dp_on  = shadow_dp[digit_idx];
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_idx > top_nz(shadow_data) && !dp_on) begin
            seg_on = '0;
            an_on  = '0;
        end
`endif
        seg_nxt = POL ? ~seg_on : seg_on;
        an_nxt  = POL ? ~an_on : an_on;
        dp_nxt  = POL ? ~dp_on : dp_on;
    end

    // Shadow capture; reset takes priority over load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else if (load) begin
            shadow_data <= data;
            shadow_dp   <= dp;
        end
    end

    // Refresh counter and digit scan index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt       <= '0;
            digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered pin drivers: all change together one clock after the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            segments       <= {7{POL}};
            dp_out         <= POL;
            Anode_Activate <= {NUM_DIGITS{POL}};
        end else begin
            segments       <= seg_nxt;
            dp_out         <= dp_nxt;
            Anode_Activate <= an_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// tb_sevenseg_scan_mux: directed + random stimulus against a cycle-count model.
// Model honours LEADING_ZERO_BLANK_EN when the macro is defined.
module tb_sevenseg_scan_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [6:0]  segments;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_data;
    logic [3:0]  m_dp;
    int          n;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sevenseg_scan_mux #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(DIV),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data(data),
        .dp(dp),
        .load(load),
        .segments(segments),
        .dp_out(dp_out),
        .Anode_Activate(an),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msd(input logic [15:0] d);
        int m;
        m = 0;
        for (int i = 0; i < N; i++)
            if (d[4*i +: 4] != 4'd0) m = i;
        return m;
    endfunction

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] p);
        logic [6:0] es;
        logic       edp;
        logic [3:0] ea;
        int         eidx;
        int         dig;
        bit         blank;
        reset = r;
        load  = ld;
        data  = d;
        dp    = p;
        @(posedge clk);
        if (r) begin
            es = 7'h7f; edp = 1'b1; ea = 4'hf; eidx = 0;
            m_data = '0; m_dp = '0; n = 0;
        end else begin
            dig   = (n / DIV) % N;
            es    = glyph[m_data[4*dig +: 4]];
            edp   = ~m_dp[dig];
            ea    = ~(4'b0001 << dig);
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (dig > msd(m_data) && !m_dp[dig]) blank = 1'b1;
`endif
            if (blank) begin
                es = 7'h7f; edp = 1'b1; ea = 4'hf;
            end
            n++;
            eidx = (n / DIV) % N;
            if (ld) begin
                m_data = d;
                m_dp   = p;
            end
        end
        #1;
        check("segments", {25'd0, segments}, {25'd0, es});
        check("dp_out", {31'd0, dp_out}, {31'd0, edp});
        check("anodes", {28'd0, an}, {28'd0, ea});
        check("digit_idx", {30'd0, digit_idx}, eidx);
    endtask

    initial begin
        int unused_msd;
        unused_msd = msd(16'h0);
        reset = 1'b1; load = 1'b0; data = '0; dp = '0;
        m_data = '0; m_dp = '0; n = 0;

        // Reset held 3 clocks, load ignored under reset.
        step(1, 0, 16'h0, 4'h0);
        step(1, 1, 16'hFFFF, 4'hF);
        step(1, 0, 16'h0, 4'h0);
        check("rst_anodes", {28'd0, an}, 32'hf);
        check("rst_seg", {25'd0, segments}, 32'h7f);
        check("rst_dp", {31'd0, dp_out}, 32'h1);

        // First edge after release shows digit 0 of a zero shadow.
        step(0, 0, 16'h0, 4'h0);
        check("first_anodes", {28'd0, an}, 32'he);
        check("first_seg", {25'd0, segments}, {25'd0, 7'b0000001});

        // Load 1234, visible two clocks after the strobe.
        step(0, 1, 16'h1234, 4'h0);
        step(0, 0, 16'h0, 4'h0);
        check("load_seg", {25'd0, segments}, {25'd0, 7'b1001100});
        for (int i = 0; i < 17; i++) step(0, 0, 16'h0, 4'h0);

        // Input change without load must not reach the display.
        for (int i = 0; i < 16; i++) step(0, 0, 16'hABCD, 4'hF);
        step(0, 1, 16'hABCD, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 0, 16'h0, 4'h0);

        // Decimal point on digit 1 only.
        step(0, 1, 16'hABCD, 4'b0010);
        for (int i = 0; i < 17; i++) step(0, 0, 16'h0, 4'h0);

        // Reset mid slot 2, then fresh scan from digit 0.
        while (((n / DIV) % N) != 2 || (n % DIV) != 1) step(0, 0, 16'h0, 4'h0);
        step(1, 0, 16'h0, 4'h0);
        step(0, 0, 16'h0, 4'h0);
        check("rerun_anodes", {28'd0, an}, 32'he);
        for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 4'h0);

        // Leading-zero words (blanked only when the feature is built in).
        step(0, 1, 16'h0050, 4'h0);
        for (int i = 0; i < 17; i++) step(0, 0, 16'h0, 4'h0);
        step(0, 1, 16'h0000, 4'h0);
        for (int i = 0; i < 17; i++) step(0, 0, 16'h0, 4'h0);
        step(0, 1, 16'h0000, 4'b1000);
        for (int i = 0; i < 17; i++) step(0, 0, 16'h0, 4'h0);

        // Random traffic, including loads at digit advances and stray resets.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] rd;
            logic [3:0]  rp;
            logic        rl;
            logic        rr;
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rd = rd & 16'h00FF;
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rl = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 99) == 0);
            step(rr, rl, rd, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
